// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for fifo_sync_param.
// The master modport is the producer/consumer side. The slave modport is the FIFO side.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32
);
    localparam int AW = $clog2(DEPTH);

    logic                  CLEAR;
    logic                  WRITE;
    logic                  READ;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic [AW:0]           USE_DW;
    logic                  F_FULL;
    logic                  F_EMPTY;
    logic                  F_ALMOST_FULL;
    logic                  F_ALMOST_EMPTY;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;

    modport master (
        output CLEAR, WRITE, READ, DATA_IN,
        input  DATA_OUT, USE_DW, F_FULL, F_EMPTY,
               F_ALMOST_FULL, F_ALMOST_EMPTY, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  CLEAR, WRITE, READ, DATA_IN,
        output DATA_OUT, USE_DW, F_FULL, F_EMPTY,
               F_ALMOST_FULL, F_ALMOST_EMPTY, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with an EMPTY/OTHER/FULL occupancy state machine.
// It has registered read data, almost-full and almost-empty thresholds,
// and sticky overflow and underflow flags.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input logic              CLOCK,
    input logic              RESET,
    fifo_sync_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    // The encodings are fixed because existing benches probe the state directly.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_OTHER = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   CNT_AF   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   CNT_AE   = (AW+1)'(AE_LEVEL);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    state_t                state;
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [AW:0]           count;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  overflow;
    logic                  underflow;

    logic full;
    logic empty;
    logic wr_ok;
    logic rd_ok;

    // A write into a full FIFO is accepted only when a read frees the slot in the same cycle.
    // A read from an empty FIFO is never accepted, so an empty FIFO does not pass data straight through.
    assign full  = (state == ST_FULL);
    assign empty = (state == ST_EMPTY);
    assign wr_ok = bus.WRITE & (~full | bus.READ);
    assign rd_ok = bus.READ & ~empty;

    // Occupancy state machine. The thresholds are taken from the pre-edge count.
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= ST_EMPTY;
        end else if (bus.CLEAR) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (wr_ok && !rd_ok) state <= ST_OTHER;
                ST_OTHER: begin
                    if (count == CNT_ONE && rd_ok && !wr_ok)
                        state <= ST_EMPTY;
                    else if (count == CNT_LAST && wr_ok && !rd_ok)
                        state <= ST_FULL;
                end
                ST_FULL:  if (rd_ok && !wr_ok) state <= ST_OTHER;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    // Pointers, count, read data register and sticky error flags.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.CLEAR) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + PTR_ONE;
            if (rd_ok) begin
                rptr     <= rptr + PTR_ONE;
                data_out <= mem[rptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (bus.WRITE && full && !bus.READ) overflow  <= 1'b1;
            if (bus.READ && empty)              underflow <= 1'b1;
        end
    end

    // Storage array write port. CLEAR suppresses the write and leaves the contents in place.
    // NOTE: the array has no reset on purpose, so that it maps to plain storage.
    // A word is never read before it has been written.
    always_ff @(posedge CLOCK) begin
        if (!bus.CLEAR && wr_ok) mem[wptr] <= bus.DATA_IN;
    end

    assign bus.DATA_OUT       = data_out;
    assign bus.USE_DW         = count;
    assign bus.F_FULL         = full;
    assign bus.F_EMPTY        = empty;
    assign bus.F_ALMOST_FULL  = (count >= CNT_AF);
    assign bus.F_ALMOST_EMPTY = (count <= CNT_AE);
    assign bus.OVERFLOW       = overflow;
    assign bus.UNDERFLOW      = underflow;
endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO, the next generation of the fixed 8-bit × 32-word FIFO. Data width, depth and almost-full/almost-empty thresholds are generic. Simultaneous read/write is fully defined, and sticky overflow/underflow error flags are added. It sits between any producer/consumer pair in the same clock domain and keeps the EMPTY/OTHER/FULL occupancy state machine, so existing FSM-level benches still apply.

## Interface
Parameters:
- DATA_WIDTH, 8, width of a data word (≥1)
- DEPTH, 32, number of storage words; power of two, ≥4
- AF_LEVEL, DEPTH-4, F_ALMOST_FULL asserts when USE_DW ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 4, F_ALMOST_EMPTY asserts when USE_DW ≤ AE_LEVEL (0..DEPTH-1)

Ports (AW = $clog2(DEPTH)):
- CLOCK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- CLEAR  in  1  synchronous flush: pointers/count to 0, errors cleared, RAM untouched
- WRITE  in  1  write request
- READ  in  1  read request
- DATA_IN  in  DATA_WIDTH  write data
- DATA_OUT  out  DATA_WIDTH  registered read data
- USE_DW  out  AW+1  words currently stored, 0..DEPTH
- F_FULL  out  1  USE_DW == DEPTH
- F_EMPTY  out  1  USE_DW == 0
- F_ALMOST_FULL  out  1  USE_DW ≥ AF_LEVEL
- F_ALMOST_EMPTY  out  1  USE_DW ≤ AE_LEVEL
- OVERFLOW  out  1  sticky; write attempted while full without a read
- UNDERFLOW  out  1  sticky; read attempted while empty

## Operation
- Storage: DEPTH × DATA_WIDTH register array; write pointer and read pointer each AW bits; count register AW+1 bits.
- Accepted write (wr_ok) = WRITE & (!F_FULL | READ). Accepted read (rd_ok) = READ & !F_EMPTY.
- wr_ok: mem[wptr] ← DATA_IN; wptr ← wptr+1 mod DEPTH (natural wrap, DEPTH is power of two).
- rd_ok: DATA_OUT ← mem[rptr]; rptr ← rptr+1 mod DEPTH. DATA_OUT holds its value when there is no rd_ok.
- Count: +1 on wr_ok only, −1 on rd_ok only, unchanged on both or neither. Never exceeds DEPTH and never goes below 0.
- State machine (2-bit, encodings match existing benches): EMPTY=2'b00, OTHER=2'b01, FULL=2'b10.
  - EMPTY → OTHER on wr_ok & !rd_ok.
  - OTHER → EMPTY when USE_DW==1 & rd_ok & !wr_ok.
  - OTHER → FULL when USE_DW==DEPTH-1 & wr_ok & !rd_ok.
  - FULL → OTHER on rd_ok & !wr_ok.
  - All other cases hold the state. State 2'b11 is unreachable and recovers to EMPTY.
- Flags F_FULL/F_EMPTY are decoded from state; almost flags are compared from the count register. All flags are registered-derived, with no combinational path from READ/WRITE.
- Boundary behaviour:
  - Empty + READ&WRITE: only the write takes effect (no fall-through). UNDERFLOW sets, count → 1.
  - Full + READ&WRITE: both take effect, count stays DEPTH, OVERFLOW does not set.
  - Full + WRITE only: data is dropped, memory and pointers unchanged, OVERFLOW sets.
  - Empty + READ only: nothing changes, DATA_OUT holds, UNDERFLOW sets.
- OVERFLOW/UNDERFLOW clear only on RESET or CLEAR.
- CLEAR has priority over READ/WRITE in the same cycle.

## Timing
- RESET asserted (asynchronous, any time, including mid-burst): state=EMPTY, wptr=rptr=0, USE_DW=0, DATA_OUT=0, F_EMPTY=1, F_FULL=0, F_ALMOST_EMPTY=1, F_ALMOST_FULL=0 (1 if AF_LEVEL==0; not legal), OVERFLOW=UNDERFLOW=0. Memory contents are undefined.
- Writes are visible to a read on the next cycle: write at edge N, READ sampled at edge N+1 returns the data after edge N+1.
- Read latency is 1 cycle: DATA_OUT is valid after the edge that samples READ.
- USE_DW, state and all flags update on the same edge as the accepted operation.
- Throughput is one write and one read per cycle, sustained.

## Test plan
- Reset/idle: assert RESET mid-sequence after 5 writes → USE_DW=0, state=EMPTY, F_EMPTY=1, DATA_OUT=0 immediately (asynchronous). After release, write 0xA5 then read → DATA_OUT=0xA5.
- Fill/drain, DEPTH=32: write 0..31 → state OTHER after the 1st write, USE_DW=31 and OTHER after the 31st, FULL after the 32nd. F_ALMOST_FULL rises at USE_DW=28. Read 32 times → data 0..31 in order, EMPTY after the last read, F_ALMOST_EMPTY rises at USE_DW=4.
- Wrap-around: write 20, read 20, write 32 values 0x40..0x5F, read 32 → exact order preserved across the pointer wrap, no flag errors.
- Simultaneous ops: when full, READ&WRITE 0x77 for 10 cycles → USE_DW stays 32, OVERFLOW=0, FIFO order preserved. When empty, READ&WRITE 0x11 → USE_DW=1, UNDERFLOW=1, DATA_OUT unchanged.
- Errors/CLEAR: when full, WRITE only → OVERFLOW=1, stored data intact. Then CLEAR with READ=1 → USE_DW=0, EMPTY, OVERFLOW=UNDERFLOW=0, DATA_OUT unchanged.
- Parameter sweep: DATA_WIDTH=16/DEPTH=4/AF_LEVEL=3/AE_LEVEL=1 → FULL at 4 words, almost flags at 3 and ≤1, 16-bit data 0xBEEF round-trips.
